// File: rtl/vending_pkg.sv
// Shared definitions for the vending machine slice: coin codes, coin values,
// the change-dispenser state encoding and a code-to-value helper.
package vending_pkg;

    typedef enum logic [1:0] {
        ten    = 2'b00,
        twenty = 2'b01,
        fifty  = 2'b10
    } coin_t;

    localparam logic [7:0] TEN_VALUE    = 8'd10;
    localparam logic [7:0] TWENTY_VALUE = 8'd20;
    localparam logic [7:0] FIFTY_VALUE  = 8'd50;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SELECT = 2'b01,
        EJECT  = 2'b10,
        DONE   = 2'b11
    } state_t;

    // Monetary value of a coin code; the unused code is worth nothing.
    function automatic logic [7:0] coin_value(input logic [1:0] code);
        case (code)
            ten:     return TEN_VALUE;
            twenty:  return TWENTY_VALUE;
            fifty:   return FIFTY_VALUE;
            default: return 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/coin_tube.sv
// One coin tube: a counter that saturates at the top and never underflows.
// A load and an eject of the same tube in one cycle cancel each other.
module coin_tube
    import vending_pkg::*;
#(
    parameter int COUNT_W    = 6,
    parameter int INIT_COUNT = 4
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               inc,
    input  logic               dec,
    output logic [COUNT_W-1:0] count
);

    localparam logic [COUNT_W-1:0] MAX_COUNT  = '1;
    localparam logic [COUNT_W-1:0] RESET_CNT  = COUNT_W'(INIT_COUNT);

    // Tube count: reload on reset, otherwise step up or down within bounds.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            count <= RESET_CNT;
        end else if (inc && !dec) begin
            if (count != MAX_COUNT) begin
                count <= count + COUNT_W'(1);
            end
        end else if (dec && !inc) begin
            if (count != '0) begin
                count <= count - COUNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Change-return controller: pays a requested amount greedily in 50/20/10
// coins through a valid/ack ejector handshake, keeps the tube inventory,
// and reports any unpaid remainder or an ejector timeout when it finishes.
module change_dispenser
    import vending_pkg::*;
#(
    parameter int COUNT_W     = 6,
    parameter int INIT_COUNT  = 4,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               Change_given,
    input  logic [7:0]         Change_out,
    input  logic               load,
    input  logic [1:0]         load_coin,
    output logic               eject_valid,
    output logic [1:0]         eject_coin,
    input  logic               eject_ack,
    output logic               busy,
    output logic               done,
    output logic               short,
    output logic [7:0]         shortfall,
    output logic               ack_fault,
    output logic [COUNT_W-1:0] cnt10,
    output logic [COUNT_W-1:0] cnt20,
    output logic [COUNT_W-1:0] cnt50
);

    // The wait counter only has to reach ACK_TIMEOUT-1.
    localparam int              TO_W     = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(ACK_TIMEOUT - 1);

    state_t          state;
    logic [7:0]      remaining;
    logic            fault;
    logic [TO_W-1:0] wait_cnt;

    logic            pick_valid;
    logic [1:0]      pick_coin;
    logic            ack_take;
    logic            inc10, inc20, inc50;
    logic            dec10, dec20, dec50;

    assign ack_take = (state == EJECT) && eject_valid && eject_ack;

    assign inc10 = load && (load_coin == ten);
    assign inc20 = load && (load_coin == twenty);
    assign inc50 = load && (load_coin == fifty);

    assign dec10 = ack_take && (eject_coin == ten);
    assign dec20 = ack_take && (eject_coin == twenty);
    assign dec50 = ack_take && (eject_coin == fifty);

    coin_tube #(.COUNT_W(COUNT_W), .INIT_COUNT(INIT_COUNT)) u_tube10 (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .inc     (inc10),
        .dec     (dec10),
        .count   (cnt10)
    );

    coin_tube #(.COUNT_W(COUNT_W), .INIT_COUNT(INIT_COUNT)) u_tube20 (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .inc     (inc20),
        .dec     (dec20),
        .count   (cnt20)
    );

    coin_tube #(.COUNT_W(COUNT_W), .INIT_COUNT(INIT_COUNT)) u_tube50 (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .inc     (inc50),
        .dec     (dec50),
        .count   (cnt50)
    );

    // Greedy coin choice: largest denomination that fits and is in stock.
    always_comb begin
        pick_valid = 1'b1;
        pick_coin  = ten;
        if ((remaining >= FIFTY_VALUE) && (cnt50 != '0)) begin
            pick_coin = fifty;
        end else if ((remaining >= TWENTY_VALUE) && (cnt20 != '0)) begin
            pick_coin = twenty;
        end else if ((remaining >= TEN_VALUE) && (cnt10 != '0)) begin
            pick_coin = ten;
        end else begin
            pick_valid = 1'b0;
        end
    end

    // Request sequencing with all handshake and status outputs registered.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state       <= IDLE;
            remaining   <= 8'd0;
            fault       <= 1'b0;
            wait_cnt    <= '0;
            eject_valid <= 1'b0;
            eject_coin  <= ten;
            busy        <= 1'b0;
            done        <= 1'b0;
            short       <= 1'b0;
            shortfall   <= 8'd0;
            ack_fault   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Change_given) begin
                        remaining <= Change_out;
                        fault     <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SELECT;
                    end
                end
                SELECT: begin
                    if (pick_valid) begin
                        eject_coin  <= pick_coin;
                        eject_valid <= 1'b1;
                        wait_cnt    <= '0;
                        state       <= EJECT;
                    end else begin
                        done      <= 1'b1;
                        short     <= (remaining != 8'd0);
                        shortfall <= remaining;
                        ack_fault <= fault;
                        state     <= DONE;
                    end
                end
                EJECT: begin
                    if (eject_ack) begin
                        eject_valid <= 1'b0;
                        remaining   <= remaining - coin_value(eject_coin);
                        state       <= SELECT;
                    end else if (wait_cnt == TO_LAST) begin
                        eject_valid <= 1'b0;
                        fault       <= 1'b1;
                        done        <= 1'b1;
                        short       <= (remaining != 8'd0);
                        shortfall   <= remaining;
                        ack_fault   <= 1'b1;
                        state       <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + TO_W'(1);
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
